ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side streaming engine for the shared dual-port control RAM. On a start command it walks a contiguous address window through one RAM read port, absorbs the RAM's one-cycle registered-address read latency, and delivers the words in order on a valid/ready stream through a small FIFO. It sits between the RAM's second port and consumers such as the OSD scan-out or the host-transfer path, so they never handle RAM addressing or timing themselves.

## Interface
- ADDRESS_WIDTH, 15, RAM address width; the address counter wraps modulo 2^ADDRESS_WIDTH.
- WORD_SIZE, 8, data word width.
- FIFO_DEPTH, 4, output buffer depth; power of two, at least 2.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- abort  in  1  cancel the current transfer.
- base  in  ADDRESS_WIDTH  first address; sampled with start.
- len  in  ADDRESS_WIDTH+1  word count, 0..2^ADDRESS_WIDTH; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion.
- ram_a  out  ADDRESS_WIDTH  registered read address to the RAM port.
- ram_q  in  WORD_SIZE  RAM read data; valid the cycle after the RAM latches ram_a.
- out_data  out  WORD_SIZE  stream data (FIFO head).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts; a word transfers on valid & ready.
- checksum  out  WORD_SIZE  present only with RAM_STREAM_CSUM_EN.

## Operation
- Reset values: ram_a=0, busy=0, done=0, out_valid=0, out_data=0, checksum=0, FIFO empty, state IDLE.
- **IDLE**:
  - If start=1 and abort=0: latch base and len, load the issue counter and the delivery counter with len, load ram_a=base, set busy=1, go to FETCH.
  - If start=1 and len=0: go straight to DONE.
- **FETCH**:
  - Each cycle the block issues a read when three conditions hold: issue count > 0, FIFO occupancy + reads in flight < FIFO_DEPTH, and abort=0.
  - An issued read means the RAM latches ram_a at this edge; ram_a then increments modulo 2^ADDRESS_WIDTH and the issue count decrements.
  - ram_q is written into the FIFO on the following edge.
  - At most one read is in flight at a time.
  - The credit check guarantees no FIFO overflow.
  - Each valid & ready handshake decrements the delivery count. When it reaches 0, go to DONE.
- **DONE**: assert done=1 for one cycle, set busy=0, go to IDLE.
- **abort** (any state other than IDLE): go to IDLE on the next edge.
  - Flush the FIFO; out_valid=0 next cycle.
  - Discard the in-flight read.
  - busy=0, no done pulse.
  - abort in IDLE has no effect and wins over a simultaneous start.
- start while busy=1 is ignored.
- Handshake rules:
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on abort or reset.
- Simultaneous FIFO write and read at full occupancy is legal; occupancy is unchanged.

## Timing
- start sampled at edge E0; ram_a=base after E0; RAM latches at E1; word 0 written to the FIFO at E2; out_valid=1 after E2.
- Start-to-first-valid latency: 2 cycles.
- Throughput: one word per cycle with out_ready held high.
- done is asserted in the cycle after the last handshake edge; busy falls at the same edge.
- ram_a holds its value whenever no read is issued.
- reset_n=0 mid-transfer: all outputs return to their reset values on that edge, and no done pulse is produced.

## Configuration
- RAM_STREAM_CSUM_EN defined:
  - checksum is the running XOR of every word handed over on the stream.
  - It clears to 0 at the accepted start and at reset, and holds its final value after done until the next start.
  - Abort leaves checksum at the partial value.
- RAM_STREAM_CSUM_EN undefined: no checksum port and no checksum logic.

## Test plan
- Basic transfer: mem[a]=a[7:0], base=0x0010, len=4, out_ready=1. Required: out_valid after E2; words 0x10,0x11,0x12,0x13 on consecutive cycles; done one cycle after the 4th handshake; busy 0 afterwards.
- Backpressure: base=0x0000, len=8, out_ready=0 for 10 cycles, then 1. Required: ram_a stalls after 4 reads; FIFO full without overflow; all 8 words delivered in order, none lost or duplicated.
- Wrap-around: base=0x7FFE, len=4. Required: ram_a sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001; data matches.
- Edge cases:
  - len=0: done pulses the cycle after E0; out_valid never rises.
  - start during busy: ignored.
- Abort and reset: abort after the 2nd handshake of an 8-word transfer gives out_valid=0 next cycle, busy=0 and no done. A following transfer then starts cleanly. reset_n=0 mid-transfer drives all outputs to their reset values.
- Checksum, with RAM_STREAM_CSUM_EN: words 0x01,0x02,0x04,0x80 give checksum=0x87 after done, holding until the next start.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streams a contiguous RAM address window out through a small valid/ready FIFO.
// Define RAM_STREAM_CSUM_EN to add a running-XOR checksum of delivered words.
module ram_stream_reader #(
   parameter int unsigned ADDRESS_WIDTH = 15,
   parameter int unsigned WORD_SIZE     = 8,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     start_i,
   input  logic                     abort_i,
   input  logic [ADDRESS_WIDTH-1:0] base_i,
   input  logic [ADDRESS_WIDTH:0]   len_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [ADDRESS_WIDTH-1:0] ram_a_o,
   input  logic [WORD_SIZE-1:0]     ram_q_i,
   output logic [WORD_SIZE-1:0]     out_data_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i
`ifdef RAM_STREAM_CSUM_EN
   ,
   output logic [WORD_SIZE-1:0]     checksum_o
`endif
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [ADDRESS_WIDTH:0] LenOne = 1;

   typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] ram_a_q, ram_a_d;
   logic [ADDRESS_WIDTH:0]   issue_cnt_q, issue_cnt_d;
   logic [ADDRESS_WIDTH:0]   deliv_cnt_q, deliv_cnt_d;
   logic                     inflight_q, inflight_d;
   logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]          fifo_cnt_q, fifo_cnt_d;
   logic [WORD_SIZE-1:0]     fifo_mem_q [FIFO_DEPTH];
   logic                     issue, fifo_wr, handshake, flush;

   assign out_valid_o = (fifo_cnt_q != '0);
   assign out_data_o  = out_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
   assign busy_o      = (state_q == StFetch);
   assign done_o      = (state_q == StDone);
   assign ram_a_o     = ram_a_q;
   assign handshake   = out_valid_o & out_ready_i;
   assign flush       = abort_i & (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      ram_a_d     = ram_a_q;
      issue_cnt_d = issue_cnt_q;
      deliv_cnt_d = deliv_cnt_q;
      inflight_d  = 1'b0;
      issue       = 1'b0;
      fifo_wr     = inflight_q;
      wr_ptr_d    = fifo_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d    = handshake ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      fifo_cnt_d  = fifo_cnt_q + CntW'(fifo_wr) - CntW'(handshake);

      unique case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
               ram_a_d     = base_i;
               issue_cnt_d = len_i;
               deliv_cnt_d = len_i;
               state_d     = (len_i == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            // Credit counts the in-flight read so the FIFO can never overflow.
            issue = (issue_cnt_q != '0) && !abort_i &&
                    ((fifo_cnt_q + CntW'(inflight_q)) < CntW'(FIFO_DEPTH));
            if (issue) begin
               ram_a_d     = ram_a_q + 1'b1;
               issue_cnt_d = issue_cnt_q - LenOne;
               inflight_d  = 1'b1;
            end
            if (handshake) begin
               deliv_cnt_d = deliv_cnt_q - LenOne;
               if (deliv_cnt_q == LenOne) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (flush) begin
         state_d    = StIdle;
         inflight_d = 1'b0;
         fifo_wr    = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fifo_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         ram_a_q     <= '0;
         issue_cnt_q <= '0;
         deliv_cnt_q <= '0;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ram_a_q     <= ram_a_d;
         issue_cnt_q <= issue_cnt_d;
         deliv_cnt_q <= deliv_cnt_d;
         inflight_q  <= inflight_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fifo_wr) fifo_mem_q[wr_ptr_q] <= ram_q_i;
   end

`ifdef RAM_STREAM_CSUM_EN
   logic [WORD_SIZE-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == StIdle && start_i && !abort_i) begin
         csum_d = '0;
      end else if (handshake) begin
         csum_d = csum_q ^ out_data_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) csum_q <= '0;
      else           csum_q <= csum_d;
   end

   assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed self-checking bench for ram_stream_reader with a registered-read RAM model.
// Checksum checks are compiled in when RAM_STREAM_CSUM_EN is defined.
module tb_ram_stream_reader;

   logic        clk = 1'b0;
   logic        reset_n, start, abort, out_ready;
   logic [14:0] base;
   logic [15:0] len;
   logic        busy, done, out_valid;
   logic [14:0] ram_a;
   logic [7:0]  ram_q, out_data;
`ifdef RAM_STREAM_CSUM_EN
   logic [7:0]  checksum;
`endif

   logic [7:0]  mem [32768];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) ram_q <= mem[ram_a];

   ram_stream_reader u_dut (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .start_i     (start),
      .abort_i     (abort),
      .base_i      (base),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .ram_a_o     (ram_a),
      .ram_q_i     (ram_q),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
`ifdef RAM_STREAM_CSUM_EN
      ,
      .checksum_o  (checksum)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [14:0] b, input logic [15:0] l);
      base  = b;
      len   = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Consume n words, comparing each against the RAM image; ends one edge after the last handshake.
   task automatic stream_check(input logic [14:0] b, input int n, input int budget);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < budget) begin
         if (out_valid && out_ready) begin
            check_eq("data", 32'(out_data), 32'(mem[15'(b + 15'(got))]));
            got++;
         end
         tick();
         cyc++;
      end
      check_eq("word_count", 32'(got), 32'(n));
      check_eq("done_after_last", 32'(done), 32'd1);
      check_eq("busy_after_last", 32'(busy), 32'd0);
      tick();
      check_eq("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
      mem[15'h200] = 8'h01;
      mem[15'h201] = 8'h02;
      mem[15'h202] = 8'h04;
      mem[15'h203] = 8'h80;

      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b1;
      base      = '0;
      len       = '0;
      tick();
      tick();
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_ram_a", 32'(ram_a), 32'd0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_data", 32'(out_data), 32'd0);
      reset_n = 1'b1;
      tick();

      // Basic transfer with explicit cycle timing
      kick(15'h0010, 16'd4);
      check_eq("basic_busy", 32'(busy), 32'd1);
      check_eq("basic_ram_a_e0", 32'(ram_a), 32'h10);
      check_eq("basic_valid_e0", 32'(out_valid), 32'd0);
      tick();
      check_eq("basic_valid_e1", 32'(out_valid), 32'd0);
      tick();
      check_eq("basic_valid_e2", 32'(out_valid), 32'd1);
      check_eq("basic_w0", 32'(out_data), 32'h10);
      tick();
      check_eq("basic_w1", 32'(out_data), 32'h11);
      tick();
      check_eq("basic_w2", 32'(out_data), 32'h12);
      tick();
      check_eq("basic_w3", 32'(out_data), 32'h13);
      check_eq("basic_done_early", 32'(done), 32'd0);
      tick();
      check_eq("basic_done", 32'(done), 32'd1);
      check_eq("basic_busy_end", 32'(busy), 32'd0);
      check_eq("basic_valid_end", 32'(out_valid), 32'd0);
      tick();
      check_eq("basic_done_clr", 32'(done), 32'd0);

      // Backpressure: four reads issued, then stall with stable head
      out_ready = 1'b0;
      kick(15'h0000, 16'd8);
      repeat (5) tick();
      check_eq("bp_head_mid", 32'(out_data), 32'h00);
      repeat (5) tick();
      check_eq("bp_ram_a_stall", 32'(ram_a), 32'h4);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_head_end", 32'(out_data), 32'h00);
      out_ready = 1'b1;
      stream_check(15'h0000, 8, 60);

      // Wrap-around of the address counter
      out_ready = 1'b0;
      kick(15'h7FFE, 16'd4);
      check_eq("wrap_a0", 32'(ram_a), 32'h7FFE);
      tick();
      check_eq("wrap_a1", 32'(ram_a), 32'h7FFF);
      tick();
      check_eq("wrap_a2", 32'(ram_a), 32'h0000);
      tick();
      check_eq("wrap_a3", 32'(ram_a), 32'h0001);
      out_ready = 1'b1;
      stream_check(15'h7FFE, 4, 30);

      // len = 0
      kick(15'h0123, 16'd0);
      check_eq("len0_done", 32'(done), 32'd1);
      check_eq("len0_busy", 32'(busy), 32'd0);
      check_eq("len0_valid", 32'(out_valid), 32'd0);
      tick();
      check_eq("len0_done_clr", 32'(done), 32'd0);
      check_eq("len0_valid_after", 32'(out_valid), 32'd0);

      // Start while busy is ignored
      kick(15'h0040, 16'd3);
      base  = 15'h0100;
      len   = 16'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      stream_check(15'h0040, 3, 30);
      check_eq("busy_start_ram_a", 32'(ram_a), 32'h43);

      // Abort after the second handshake
      kick(15'h0000, 16'd8);
      tick();
      tick();
      check_eq("abort_w0", 32'(out_data), 32'h00);
      tick();
      check_eq("abort_w1", 32'(out_data), 32'h01);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_valid", 32'(out_valid), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      tick();
      check_eq("abort_no_done", 32'(done), 32'd0);
      kick(15'h0020, 16'd2);
      stream_check(15'h0020, 2, 30);

      // Abort in idle wins over start
      base  = 15'h0050;
      len   = 16'd2;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_eq("idle_abort_busy", 32'(busy), 32'd0);
      check_eq("idle_abort_done", 32'(done), 32'd0);

      // Reset mid-transfer
      out_ready = 1'b0;
      kick(15'h0300, 16'd8);
      repeat (4) tick();
      reset_n = 1'b0;
      tick();
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_done", 32'(done), 32'd0);
      check_eq("mrst_ram_a", 32'(ram_a), 32'd0);
      check_eq("mrst_valid", 32'(out_valid), 32'd0);
      check_eq("mrst_data", 32'(out_data), 32'd0);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();
      check_eq("mrst_no_done", 32'(done), 32'd0);

`ifdef RAM_STREAM_CSUM_EN
      kick(15'h0200, 16'd4);
      check_eq("csum_clear", 32'(checksum), 32'd0);
      stream_check(15'h0200, 4, 30);
      check_eq("csum_final", 32'(checksum), 32'h87);
      repeat (3) tick();
      check_eq("csum_hold", 32'(checksum), 32'h87);
      kick(15'h0000, 16'd0);
      check_eq("csum_restart", 32'(checksum), 32'd0);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
